// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream FIFO slice.
// The beat type uses the default stream width; wider instances build their own beat vector.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic                       last;
    } axis_beat_t;

    typedef enum logic {
        GATED  = 1'b0,
        STREAM = 1'b1
    } pkt_state_e;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, synchronous registered read.
// The read register doubles as the FIFO output register, so it clears on reset.
module axis_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_fifo_pkt.sv
// Buffered AXI-Stream FIFO with fill/packet status and an optional whole-packet release mode.
// Capacity counts the output register; the RAM read register is that output register.
module axis_fifo_pkt
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_THRESH = DEPTH - 2,
    parameter int PACKET_MODE        = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [cnt_width(DEPTH)-1:0] fill_level,
    output logic                        almost_full,
    output logic [cnt_width(DEPTH)-1:0] pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = cnt_width(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic [CW-1:0]     pkt_q, pkt_d;
    logic [CW-1:0]     pkt_in_ram;
    logic              m_valid_q, m_valid_d;
    logic              s_ready_q, s_ready_d;
    logic              accept, deliver, ram_empty, holding_last;
    logic              force_stream, gate_open, load;
    logic [DATA_WIDTH:0] rd_beat;
    pkt_state_e        state_q;

    always_comb begin
        accept       = s_axis_tvalid && s_ready_q;
        deliver      = m_valid_q && m_axis_tready;
        ram_empty    = (wr_ptr_q == rd_ptr_q);
        holding_last = m_valid_q && m_axis_tlast;
        // Complete packets still waiting in RAM, not counting the one sitting in the output register.
        pkt_in_ram   = pkt_q - CW'(holding_last);
        force_stream = (fill_q == CW'(DEPTH)) && (pkt_q == '0);
        gate_open    = (PACKET_MODE == 0)
                    || ((state_q == STREAM) && !holding_last)
                    || (pkt_in_ram != '0)
                    || force_stream;
        load         = !ram_empty && (!m_valid_q || m_axis_tready) && gate_open;

        wr_ptr_d  = wr_ptr_q + PW'(accept);
        rd_ptr_d  = rd_ptr_q + PW'(load);
        fill_d    = fill_q + CW'(accept) - CW'(deliver);
        pkt_d     = pkt_q + CW'(accept && s_axis_tlast) - CW'(deliver && m_axis_tlast);
        // Ready follows the next fill level, so a delivery while full frees space one cycle later.
        s_ready_d = (fill_d < CW'(DEPTH));
        m_valid_d = m_valid_q;
        if (load) begin
            m_valid_d = 1'b1;
        end else if (deliver) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            pkt_q     <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            pkt_q     <= pkt_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

    if (PACKET_MODE != 0) begin : g_pkt_fsm
        pkt_state_e state_d;

        // A load always starts or continues a packet; the tlast delivery ends it.
        always_comb begin
            state_d = state_q;
            if (deliver && m_axis_tlast) begin
                state_d = GATED;
            end
            if (load) begin
                state_d = STREAM;
            end
        end

        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                state_q <= GATED;
            end else begin
                state_q <= state_d;
            end
        end
    end else begin : g_no_fsm
        assign state_q = STREAM;
    end

    axis_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (load),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_beat)
    );

    assign m_axis_tlast  = rd_beat[DATA_WIDTH];
    assign m_axis_tdata  = rd_beat[DATA_WIDTH-1:0];
    assign m_axis_tvalid = m_valid_q;
    assign s_axis_tready = s_ready_q;
    assign fill_level    = fill_q;
    assign pkt_count     = pkt_q;
    assign almost_full   = (int'(fill_q) >= ALMOST_FULL_THRESH);

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Directed and soak bench for axis_fifo_pkt: instance A streams words, instance B releases whole packets.
module tb_axis_fifo_pkt;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [DW-1:0] a_s_data = '0, b_s_data = '0;
    logic          a_s_last = 1'b0, a_s_valid = 1'b0, a_m_ready = 1'b0;
    logic          b_s_last = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b0;
    logic [DW-1:0] a_m_data, b_m_data;
    logic          a_s_ready, a_m_last, a_m_valid, a_af;
    logic          b_s_ready, b_m_last, b_m_valid, b_af;
    logic [CW-1:0] a_fill, a_pkt, b_fill, b_pkt;

    axis_fifo_pkt #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(DEPTH - 2), .PACKET_MODE(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(a_s_data), .s_axis_tlast(a_s_last), .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready),
        .m_axis_tdata(a_m_data), .m_axis_tlast(a_m_last), .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready),
        .fill_level(a_fill), .almost_full(a_af), .pkt_count(a_pkt)
    );

    axis_fifo_pkt #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(DEPTH - 2), .PACKET_MODE(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(b_s_data), .s_axis_tlast(b_s_last), .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready),
        .m_axis_tdata(b_m_data), .m_axis_tlast(b_m_last), .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready),
        .fill_level(b_fill), .almost_full(b_af), .pkt_count(b_pkt)
    );

    logic [DW:0] exp_a[$];
    logic [DW:0] exp_b[$];
    logic [DW:0] e_a, e_b;
    int acc_a = 0, del_a = 0, acc_b = 0, del_b = 0;
    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: handshakes are observed mid-cycle and take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (a_s_valid && a_s_ready) begin
                exp_a.push_back({a_s_last, a_s_data});
                acc_a++;
            end
            if (a_m_valid && a_m_ready) begin
                if (exp_a.size() > 0) e_a = exp_a.pop_front();
                else e_a = 'x;
                check("a_beat", {a_m_last, a_m_data}, e_a);
                del_a++;
            end
            if (b_s_valid && b_s_ready) begin
                exp_b.push_back({b_s_last, b_s_data});
                acc_b++;
            end
            if (b_m_valid && b_m_ready) begin
                if (exp_b.size() > 0) e_b = exp_b.pop_front();
                else e_b = 'x;
                check("b_beat", {b_m_last, b_m_data}, e_b);
                del_b++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, prev, cyc, base_a, base_b, base_del, max_fill, prev_a, prev_b, lasts;
        bit seen;

        // ---------------- reset ----------------
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_a_m_valid", a_m_valid, 0);
        check("rst_a_m_data", a_m_data, 0);
        check("rst_a_m_last", a_m_last, 0);
        check("rst_a_s_ready", a_s_ready, 0);
        check("rst_a_fill", a_fill, 0);
        check("rst_a_af", a_af, 0);
        check("rst_a_pkt", a_pkt, 0);
        check("rst_b_m_valid", b_m_valid, 0);
        check("rst_b_s_ready", b_s_ready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rel_a_s_ready", a_s_ready, 1);
        check("rel_b_s_ready", b_s_ready, 1);

        // ---------------- fill to capacity, then drain ----------------
        a_m_ready = 1'b0;
        v = 1; cyc = 0;
        while (v <= 16 && cyc < 40) begin
            a_s_data = v; a_s_valid = 1'b1; prev = acc_a;
            @(posedge clk); #1; cyc++;
            if (acc_a != prev) begin
                if (v == 13) check("af_after_13", a_af, 0);
                if (v == 14) check("af_after_14", a_af, 1);
                v++;
            end
        end
        a_s_data = 32'h11;
        repeat (3) begin @(posedge clk); #1; end
        check("full_accepts", acc_a, 16);
        check("full_s_ready", a_s_ready, 0);
        check("full_fill", a_fill, 16);
        check("full_af", a_af, 1);
        check("full_head", a_m_data, 32'h1);
        a_s_valid = 1'b0;
        a_m_ready = 1'b1;
        @(posedge clk); #1;
        check("ready_after_deliver", a_s_ready, 1);
        check("fill_after_deliver", a_fill, 15);
        cyc = 0;
        while (del_a < 16 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("drain_count", del_a, 16);
        check("drain_fill", a_fill, 0);
        check("drain_sb", exp_a.size(), 0);

        // ---------------- latency and full-rate streaming ----------------
        base_a = acc_a; base_del = del_a; max_fill = 0;
        for (int i = 0; i < 16; i++) begin
            a_s_data = 32'hA0 + i; a_s_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 0) check("lat_edge0_valid", a_m_valid, 0);
            if (i == 1) begin
                check("lat_edge1_valid", a_m_valid, 1);
                check("lat_edge1_data", a_m_data, 32'hA0);
            end
            if (int'(a_fill) > max_fill) max_fill = int'(a_fill);
        end
        a_s_valid = 1'b0;
        check("stream_accepts", acc_a - base_a, 16);
        repeat (2) @(posedge clk); #1;
        check("stream_delivered", del_a - base_del, 16);
        check("stream_fill_le2", max_fill <= 2, 1);

        // ---------------- packet mode: 3-word packet with gaps ----------------
        b_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_s_data = 32'hB1 + i; b_s_last = (i == 2); b_s_valid = 1'b1;
            @(posedge clk); #1;
            b_s_valid = 1'b0; b_s_last = 1'b0;
            check("pkt_hold", b_m_valid, 0);
            if (i < 2) begin
                repeat (2) begin @(posedge clk); #1; check("pkt_gap_hold", b_m_valid, 0); end
            end
        end
        check("pkt_cnt_stored", b_pkt, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("pkt_out_valid", b_m_valid, 1);
            check("pkt_out_data", b_m_data, 32'hB1 + i);
            check("pkt_out_last", b_m_last, (i == 2));
            check("pkt_out_cnt", b_pkt, 1);
        end
        @(posedge clk); #1;
        check("pkt_done_valid", b_m_valid, 0);
        check("pkt_done_cnt", b_pkt, 0);

        // ---------------- packet mode: oversize packet forces streaming ----------------
        base_del = del_b; v = 0; cyc = 0; seen = 1'b0;
        while (v < 20 && cyc < 100) begin
            b_s_data = 32'hC00 + v; b_s_last = (v == 19); b_s_valid = 1'b1; prev = acc_b;
            @(posedge clk); #1; cyc++;
            if (acc_b != prev) v++;
            if (b_m_valid && !seen) begin
                seen = 1'b1;
                check("force_fill", b_fill, 16);
                check("force_data", b_m_data, 32'hC00);
            end
        end
        b_s_valid = 1'b0; b_s_last = 1'b0;
        check("over_accepts", v, 20);
        check("over_forced", seen, 1);
        cyc = 0;
        while ((del_b - base_del) < 20 && cyc < 60) begin @(posedge clk); #1; cyc++; end
        check("over_delivered", del_b - base_del, 20);
        check("over_fill", b_fill, 0);
        check("over_pkt", b_pkt, 0);

        // ---------------- random soak on both instances ----------------
        base_a = acc_a; base_b = acc_b; prev_a = acc_a; prev_b = acc_b; cyc = 0;
        while (((acc_a - base_a) < 1000 || (acc_b - base_b) < 400) && cyc < 8000) begin
            if (!(a_s_valid && acc_a == prev_a)) begin
                if ((acc_a - base_a) < 1000 && $urandom_range(0, 3) != 0) begin
                    a_s_valid = 1'b1; a_s_data = $urandom; a_s_last = ($urandom_range(0, 7) == 0);
                end else begin
                    a_s_valid = 1'b0;
                end
            end
            if (!(b_s_valid && acc_b == prev_b)) begin
                if ((acc_b - base_b) < 400 && $urandom_range(0, 3) != 0) begin
                    b_s_valid = 1'b1; b_s_data = $urandom;
                    b_s_last = ($urandom_range(0, 5) == 0) || ((acc_b - base_b) == 399);
                end else begin
                    b_s_valid = 1'b0;
                end
            end
            a_m_ready = ($urandom_range(0, 9) >= 3);
            b_m_ready = ($urandom_range(0, 9) >= 3);
            prev_a = acc_a; prev_b = acc_b;
            @(posedge clk); #1; cyc++;
            if (cyc % 128 == 0) begin
                check("soak_a_fill", a_fill, exp_a.size());
                check("soak_b_fill", b_fill, exp_b.size());
                lasts = 0;
                foreach (exp_b[k]) if (exp_b[k][DW]) lasts++;
                check("soak_b_pkt", b_pkt, lasts);
            end
        end
        a_s_valid = 1'b0; b_s_valid = 1'b0; a_s_last = 1'b0; b_s_last = 1'b0;
        a_m_ready = 1'b1; b_m_ready = 1'b1;
        cyc = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && cyc < 200) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        check("soak_a_accepts", acc_a - base_a, 1000);
        check("soak_b_accepts", acc_b - base_b, 400);
        check("soak_a_sb_empty", exp_a.size(), 0);
        check("soak_b_sb_empty", exp_b.size(), 0);
        check("soak_a_fill_end", a_fill, 0);
        check("soak_b_fill_end", b_fill, 0);
        check("soak_b_pkt_end", b_pkt, 0);

        // ---------------- reset in the middle of a burst ----------------
        a_m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_s_data = 32'hE0 + i; a_s_last = 1'b0; a_s_valid = 1'b1;
            @(posedge clk); #1;
        end
        a_s_valid = 1'b0;
        check("prerst_valid", a_m_valid, 1);
        check("prerst_fill", a_fill, 5);
        #2 rst_n = 1'b1;
        exp_a.delete(); exp_b.delete();
        #1;
        check("midrst_valid", a_m_valid, 0);
        check("midrst_data", a_m_data, 0);
        check("midrst_fill", a_fill, 0);
        check("midrst_s_ready", a_s_ready, 0);
        check("midrst_af", a_af, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("postrst_s_ready", a_s_ready, 1);
        check("postrst_valid", a_m_valid, 0);
        check("postrst_fill", a_fill, 0);
        a_m_ready = 1'b1; base_del = del_a;
        a_s_data = 32'hD1; a_s_last = 1'b1; a_s_valid = 1'b1;
        @(posedge clk); #1;
        a_s_valid = 1'b0; a_s_last = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("postrst_delivered", del_a - base_del, 1);
        check("postrst_sb_empty", exp_a.size(), 0);
        check("postrst_fill_end", a_fill, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_fifo_pkt.md
Name: axis_fifo_pkt

Overview:
- Parametrised synchronous AXI-Stream FIFO. It is the buffered successor to the single-entry axis_register slice.
- Adds configurable depth, tlast carriage, fill-level and almost-full status, and an optional packet mode that holds output until a whole packet is stored.
- Sits between stream producers and consumers in the trading datapath (feed parser → order logic) to absorb bursts and backpressure.

Parameters:
- DATA_WIDTH, 32, tdata width in bits (≥1)
- DEPTH, 16, total word capacity including the output register; power of 2, ≥2
- ALMOST_FULL_THRESH, DEPTH-2, almost_full asserts when fill_level ≥ this value
- PACKET_MODE, 0, 0 = word streaming; 1 = release only complete packets

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tlast  in  1  input end-of-packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  output data (registered)
- m_axis_tlast  out  1  output end-of-packet (registered)
- m_axis_tvalid  out  1  output valid (registered)
- m_axis_tready  in  1  output ready
- fill_level  out  $clog2(DEPTH+1)  words accepted and not yet delivered
- almost_full  out  1  fill_level ≥ ALMOST_FULL_THRESH
- pkt_count  out  $clog2(DEPTH+1)  complete packets (tlast words) held

Behaviour:
- Reset (rst_n=1, async assert, sync-deassert-safe): pointers, fill_level and pkt_count go to 0. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0 while in reset, almost_full=0. Storage contents are don't-care.
- First cycle after reset release: s_axis_tready=1.
- Handshakes: input accepted on an edge with s_axis_tvalid & s_axis_tready; output delivered on an edge with m_axis_tvalid & m_axis_tready.
- AXI rules hold: once m_axis_tvalid=1, it and the data stay stable until delivered. tvalid never depends combinationally on tready.
- s_axis_tready = (fill_level < DEPTH). It is derived from registered state only; there is no combinational path from m_axis_tready. When full, a simultaneous delivery does not allow a same-cycle accept; ready rises the next cycle.
- Latency: word accepted at edge k, FIFO otherwise empty → m_axis_tvalid=1 after edge k+1 (PACKET_MODE=0).
- Throughput: 1 word/cycle sustained when not full and m_axis_tready=1.
- Internals: circular RAM plus output register. Read/write pointers are $clog2(DEPTH) wide with an extra wrap bit. Full/empty is decided by wrap-bit compare; pointers wrap DEPTH-1 → 0.
- fill_level: +1 on accept, −1 on deliver, unchanged when both occur in the same cycle. Range 0..DEPTH; never overflows or underflows.
- pkt_count: +1 on accept with tlast=1, −1 on deliver with tlast=1, net 0 when both occur. Maintained in both modes.
- Order: words leave in arrival order. tdata and tlast stay paired.
- PACKET_MODE=1 state machine, two states:
  - GATED: output register loads only when pkt_count>0 or the force condition holds.
  - STREAM: entered when the first word of a packet is loaded. Words load freely until the word with tlast=1 is delivered, then return to GATED.
  - Force condition (prevents deadlock on packets longer than DEPTH): fill_level==DEPTH && pkt_count==0 → enter STREAM.
- PACKET_MODE=0: permanently streaming; the state machine is removed.
- tvalid=0 input cycles (bubbles) and m_axis_tready stalls have no effect on stored data.
- Mid-operation reset: all words are discarded immediately; outputs return to reset values asynchronously.

Decomposition:
- Package axis_pkg:
  - typedef axis_beat_t {data, last} parameterised by DATA_WIDTH via a macro or localparam default 32
  - enum pkt_state_e {GATED, STREAM}
  - function clog2-based width helper
- One sub-module: axis_fifo_ram, a simple dual-port DEPTH×(DATA_WIDTH+1) RAM with sync write and sync read.
- Pointer, count and state logic stays in the top module.

Test Plan:
- Reset values: hold rst_n=1 10 cycles → all outputs 0, fill_level=0. Release → s_axis_tready=1 next cycle.
- Fill (DEPTH=16, m_axis_tready=0): send 0x1..0x10 → exactly 16 accepts, s_axis_tready=0, fill_level=16, almost_full=1 from the 14th word. Then m_axis_tready=1 → 0x1..0x10 delivered in order, fill_level back to 0.
- Latency and full-rate streaming: m_axis_tready=1, continuous input 0xA0..0xAF → first m_axis_tvalid one edge after the first accept; 1 word/cycle; fill_level ≤2.
- PACKET_MODE=1: send 3 words (tlast on the 3rd) with 2-cycle gaps → m_axis_tvalid stays 0 until the tlast word is accepted, then 3 consecutive deliveries with pkt_count 1→0.
- PACKET_MODE=1 oversize: 20-word packet, DEPTH=16, m_axis_tready=1 → force condition at fill_level=16, all 20 words delivered in order, no deadlock.
- Random soak plus reset: 1000 random words, 25 % input bubbles, 30 % output stalls, scoreboard compare, zero mismatches. Assert rst_n mid-burst → m_axis_tvalid=0 immediately, fill_level=0, scoreboard flushed.
